// File: rtl/calc_pkg.sv
// calc_pkg: key codes, op encodings and FSM states shared by the key sequencer.
package calc_pkg;
    localparam logic [4:0] KEY_ADD = 5'h10;
    localparam logic [4:0] KEY_SUB = 5'h11;
    localparam logic [4:0] KEY_MUL = 5'h12;
    localparam logic [4:0] KEY_DIV = 5'h13;
    localparam logic [4:0] KEY_EQ  = 5'h14;
    localparam logic [4:0] KEY_CLR = 5'h15;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    typedef enum logic [2:0] {S_IDLE, S_A, S_OP, S_B, S_HOLD} state_t;
endpackage

// File: rtl/calc_key_timer.sv
// calc_key_timer: idle down-counter; expire pulses when the count runs out while enabled.
module calc_key_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    logic [CW-1:0] cnt_q, cnt_d;
    // A full count means no idle time has elapsed yet.
    always_comb begin
        cnt_d = clr ? LOAD : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        expire = (TIMEOUT_CYC > 0) && en && !clr && cnt_q == '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= LOAD;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: assembles A/op/B from key events, drives the calculator
// and holds its result on a valid/ready interface.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          key_code,
    input  logic                key_valid,
    output logic                key_ready,
    output logic [DATA_W-1:0]   calc_a,
    output logic [DATA_W-1:0]   calc_b,
    output logic [1:0]          calc_op,
    input  logic [2*DATA_W-1:0] calc_result,
    input  logic                calc_error,
    output logic [2*DATA_W-1:0] res_data,
    output logic                res_error,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                timeout
);
    state_t state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [1:0] op_q, op_d;
    logic [2*DATA_W-1:0] rd_q, rd_d;
    logic re_q, re_d, rv_q, rv_d, to_q, to_d;
    logic take, is_digit, is_op, is_def, entry, expire;
    assign key_ready = state_q != S_HOLD;
    assign take = key_valid && key_ready;
    assign is_digit = !key_code[4];
    assign is_op = key_code >= KEY_ADD && key_code <= KEY_DIV;
    assign is_def = key_code <= KEY_CLR;
    assign entry = state_q inside {S_A, S_OP, S_B};
    assign calc_a = a_q;
    assign calc_b = b_q;
    assign calc_op = op_q;
    assign res_data = rd_q;
    assign res_error = re_q;
    assign res_valid = rv_q;
    assign timeout = to_q;
    calc_key_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    ((take && is_def) || !entry),
        .en     (entry),
        .expire (expire)
    );
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        rd_d = rd_q;
        re_d = re_q;
        rv_d = rv_q;
        case (state_q)
            S_IDLE: if (take && is_digit) begin
                a_d = DATA_W'(key_code[3:0]);
                state_d = S_A;
            end
            S_A: if (take && is_digit) a_d = DATA_W'(key_code[3:0]);
                 else if (take && is_op) begin
                     op_d = key_code[1:0];
                     state_d = S_OP;
                 end
            S_OP: if (take && is_op) op_d = key_code[1:0];
                  else if (take && is_digit) begin
                      b_d = DATA_W'(key_code[3:0]);
                      state_d = S_B;
                  end
            S_B: if (take && is_digit) b_d = DATA_W'(key_code[3:0]);
                 else if (take && key_code == KEY_EQ) begin
                     rd_d = calc_result;
                     re_d = calc_error;
                     rv_d = 1'b1;
                     state_d = S_HOLD;
                 end
            S_HOLD: if (res_ready) rv_d = 1'b0;
            default: state_d = S_IDLE;
        endcase
        // Handshake, clear key and timeout all abandon the entry the same way.
        if ((state_q == S_HOLD && res_ready) || (take && key_code == KEY_CLR) || expire) begin
            a_d = '0;
            b_d = '0;
            op_d = OP_ADD;
            state_d = S_IDLE;
        end
        to_d = expire;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q <= '0;
            b_q <= '0;
            op_q <= OP_ADD;
            rd_q <= '0;
            re_q <= 1'b0;
            rv_q <= 1'b0;
            to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            rd_q <= rd_d;
            re_q <= re_d;
            rv_q <= rv_d;
            to_q <= to_d;
        end
    end
endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: directed key sequences checked against a phase-level model
// every cycle, plus literal expectations on the documented results.
module tb_calc_key_sequencer;
    localparam int TO = 8;
    logic clk = 0, rst = 0, key_valid = 0, res_ready = 1;
    logic [4:0] key_code = 0;
    logic key_ready, calc_error, res_error, res_valid, timeout;
    logic [3:0] calc_a, calc_b;
    logic [1:0] calc_op;
    logic [7:0] calc_result, res_data;
    int tests = 0, fails = 0;

    calc_key_sequencer #(.DATA_W(4), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op),
        .calc_result(calc_result), .calc_error(calc_error), .res_data(res_data),
        .res_error(res_error), .res_valid(res_valid), .res_ready(res_ready),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] calc(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0: return {1'b0, 8'(a) + 8'(b)};
            2'd1: return {1'b0, 8'(a) - 8'(b)};
            2'd2: return {1'b0, 8'(a) * 8'(b)};
            default: return b == 0 ? 9'h100 : {1'b0, 8'(a / b)};
        endcase
    endfunction

    always_comb {calc_error, calc_result} = calc(calc_a, calc_b, calc_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 have A, 2 have op, 3 have B, 4 holding result.
    int ph = 0, idle = 0;
    logic [3:0] ma = 0, mb = 0;
    logic [1:0] mop = 0;
    logic [7:0] mres = 0;
    logic merr = 0, mval = 0, mto = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; idle = 0; ma = 0; mb = 0; mop = 0; mres = 0; merr = 0; mval = 0; mto = 0;
        end else begin
            mto = 0;
            if (ph == 4) begin
                if (res_ready) begin mval = 0; ph = 0; ma = 0; mb = 0; mop = 0; end
            end else if (key_valid && key_code <= 5'h15) begin
                idle = 0;
                if (key_code == 5'h15) begin ph = 0; ma = 0; mb = 0; mop = 0; end
                else if (key_code < 5'h10) begin
                    if (ph <= 1) begin ma = key_code[3:0]; ph = 1; end
                    else begin mb = key_code[3:0]; ph = 3; end
                end else if (key_code <= 5'h13) begin
                    if (ph == 1 || ph == 2) begin mop = key_code[1:0]; ph = 2; end
                end else if (key_code == 5'h14 && ph == 3) begin
                    {merr, mres} = calc(ma, mb, mop);
                    mval = 1; ph = 4;
                end
            end else if (ph != 0) begin
                idle++;
                if (idle == TO) begin ph = 0; idle = 0; ma = 0; mb = 0; mop = 0; mto = 1; end
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("key_ready", key_ready, ph != 4);
        chk("calc_a", calc_a, ma);
        chk("calc_b", calc_b, mb);
        chk("calc_op", calc_op, mop);
        chk("res_valid", res_valid, mval);
        chk("res_data", res_data, mres);
        chk("res_error", res_error, merr);
        chk("timeout", timeout, mto);
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [4:0] k);
        @(negedge clk); #1;
        key_code = k; key_valid = 1;
        @(posedge clk); #1;
        key_valid = 0;
    endtask

    task automatic result(input string name, input logic [7:0] d, input logic e);
        chk({name, "_valid"}, res_valid, 1);
        chk({name, "_data"}, res_data, d);
        chk({name, "_error"}, res_error, e);
        tick;
        chk({name, "_drop"}, res_valid, 0);
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_key_ready", key_ready, 1);
        chk("rst_calc_a", calc_a, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_timeout", timeout, 0);
        @(negedge clk); #1 rst = 0;

        send(5'h07); send(5'h10); send(5'h05);
        chk("add_a", calc_a, 7); chk("add_b", calc_b, 5); chk("add_op", calc_op, 0);
        send(5'h14);
        result("add", 8'h0C, 0);

        send(5'h0F); send(5'h12); send(5'h0F); send(5'h14);
        result("mul", 8'hE1, 0);
        send(5'h03); send(5'h11); send(5'h05); send(5'h14);
        result("sub", 8'hFE, 0);
        send(5'h09); send(5'h13); send(5'h00); send(5'h14);
        result("div0", 8'h00, 1);

        send(5'h02); send(5'h06); send(5'h14); send(5'h10); send(5'h11); send(5'h04);
        chk("ow_a", calc_a, 6); chk("ow_op", calc_op, 1); chk("ow_b", calc_b, 4);
        send(5'h14);
        result("ow", 8'h02, 0);

        res_ready = 0;
        send(5'h01); send(5'h10); send(5'h01); send(5'h14);
        for (int i = 0; i < 5; i++) begin
            send(i % 2 ? 5'h01 : 5'h15);
            chk("bp_key_ready", key_ready, 0);
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 8'h02);
        end
        res_ready = 1;
        tick;
        chk("bp_done_valid", res_valid, 0);
        chk("bp_done_a", calc_a, 0);
        chk("bp_done_ready", key_ready, 1);

        send(5'h03);
        repeat (TO - 1) tick;
        chk("to_early", timeout, 0);
        chk("to_early_a", calc_a, 3);
        tick;
        chk("to_pulse", timeout, 1);
        chk("to_a", calc_a, 0);
        tick;
        chk("to_single", timeout, 0);

        send(5'h03);
        repeat (TO - 1) tick;
        send(5'h05);
        chk("race_no_pulse", timeout, 0);
        chk("race_a", calc_a, 5);
        repeat (TO - 1) tick;
        chk("race_rearm_quiet", timeout, 0);
        tick;
        chk("race_rearm_pulse", timeout, 1);

        send(5'h04); send(5'h12); send(5'h1F); send(5'h15);
        chk("clr_a", calc_a, 0); chk("clr_op", calc_op, 0);

        res_ready = 0;
        send(5'h01); send(5'h10); send(5'h01); send(5'h14);
        chk("hold_valid", res_valid, 1);
        #2 rst = 1;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_ready", key_ready, 1);
        @(negedge clk); #1 rst = 0;
        res_ready = 1;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
